mult_wb_initiator: RTL and testbench

MULT_WB_INITIATOR -- requirements
Module: mult_wb_initiator

---
 rtl/mult_wb_pkg.sv | 27 ++
 rtl/wb_ack_timer.sv | 36 +++
 rtl/mult_wb_initiator.sv | 190 +++++++++++++++++++
 tb/tb_mult_wb_initiator.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_wb_pkg.sv
// mult_wb_pkg
// Definitions shared by the multiplier Wishbone initiator and the multiplier
// register slave: register offsets, operand/product widths and the
// initiator's FSM state encoding.
package mult_wb_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  localparam logic [7:0] A_OFF = 8'h00;
  localparam logic [7:0] B_OFF = 8'h04;
  localparam logic [7:0] P_OFF = 8'h08;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    WR_B = 3'd2,
    RD_P = 3'd3,
    RESP = 3'd4
  } state_t;

  // True for the states that drive a Wishbone cycle.
  function automatic logic is_wb_state(state_t s);
    return (s == WR_A) || (s == WR_B) || (s == RD_P);
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// wb_ack_timer
// Per-transfer acknowledge wait timer. 8-bit down-counter: 'clear' loads
// LOAD, 'enable' counts down and the count holds at zero. 'expired' is
// the terminal-count compare, so with LOAD = N-1 it is high on the N-th
// cycle of a transfer.
// Ports:
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   clear     reload the counter (start of a transfer)
//   enable    count this cycle
//   expired   counter has reached terminal count
module wb_ack_timer #(
  parameter logic [7:0] LOAD = 8'd254
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expired = (cnt == 8'd0);

endmodule

// File: rtl/mult_wb_initiator.sv
// mult_wb_initiator
// Accepts an operand pair, writes A and B to the multiplier register block
// over Wishbone, reads the product back and presents it as a response.
// A transfer that is not acknowledged within TIMEOUT cycles aborts the
// command and returns an error response with a zero product.
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o       command handshake, operands cmd_a_i/cmd_b_i
//   rsp_valid_o/rsp_ready_i       response handshake, rsp_p_o product, rsp_err_o timeout
//   wbm_*                         Wishbone master port
//   busy_o                        high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready_o high
// WR_A  | writing operand A to BASE_ADDR + A_OFF
// WR_B  | writing operand B to BASE_ADDR + B_OFF
// RD_P  | reading the product from BASE_ADDR + P_OFF
// RESP  | holding the response until rsp_ready_i
module mult_wb_initiator
  import mult_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OP_W-1:0]   cmd_a_i,
  input  logic [OP_W-1:0]   cmd_b_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [PROD_W-1:0] rsp_p_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [31:0]       wbm_dat_i,
  output logic              busy_o
);

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic [OP_W-1:0]   a_q, b_q, a_nxt, b_nxt;
  logic [PROD_W-1:0] rsp_p_nxt;
  logic              rsp_err_nxt, rsp_valid_nxt, busy_nxt, cmd_ready_nxt;
  logic              cyc_nxt, stb_nxt, we_nxt;
  logic [3:0]        sel_nxt;
  logic [31:0]       adr_nxt, dat_nxt;
  logic              timed_out;
  logic              tmr_clear, tmr_en, tmr_expired;

  wb_ack_timer #(
    .LOAD (TMR_LOAD)
  ) u_ack_timer (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clear    (tmr_clear),
    .enable   (tmr_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt   = state;
    a_nxt       = a_q;
    b_nxt       = b_q;
    rsp_p_nxt   = rsp_p_o;
    rsp_err_nxt = rsp_err_o;
    timed_out   = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          a_nxt       = cmd_a_i;
          b_nxt       = cmd_b_i;
          rsp_err_nxt = 1'b0;
          state_nxt   = WR_A;
        end
      end
      // An ack in the expiry cycle still completes the transfer.
      WR_A: begin
        if (wbm_ack_i)        state_nxt = WR_B;
        else if (tmr_expired) timed_out = 1'b1;
      end
      WR_B: begin
        if (wbm_ack_i)        state_nxt = RD_P;
        else if (tmr_expired) timed_out = 1'b1;
      end
      RD_P: begin
        if (wbm_ack_i) begin
          rsp_p_nxt = wbm_dat_i;
          state_nxt = RESP;
        end else if (tmr_expired) begin
          timed_out = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (timed_out) begin
      state_nxt   = RESP;
      rsp_err_nxt = 1'b1;
      rsp_p_nxt   = '0;
    end

    // Outputs are registered, so they are decoded from the next state.
    cyc_nxt = 1'b0;
    stb_nxt = 1'b0;
    we_nxt  = 1'b0;
    sel_nxt = 4'h0;
    adr_nxt = 32'h0;
    dat_nxt = 32'h0;
    case (state_nxt)
      WR_A: begin
        cyc_nxt = 1'b1;
        stb_nxt = 1'b1;
        we_nxt  = 1'b1;
        sel_nxt = 4'hF;
        adr_nxt = BASE_ADDR + {24'h0, A_OFF};
        dat_nxt = {{(32-OP_W){1'b0}}, a_nxt};
      end
      WR_B: begin
        cyc_nxt = 1'b1;
        stb_nxt = 1'b1;
        we_nxt  = 1'b1;
        sel_nxt = 4'hF;
        adr_nxt = BASE_ADDR + {24'h0, B_OFF};
        dat_nxt = {{(32-OP_W){1'b0}}, b_nxt};
      end
      RD_P: begin
        cyc_nxt = 1'b1;
        stb_nxt = 1'b1;
        sel_nxt = 4'hF;
        adr_nxt = BASE_ADDR + {24'h0, P_OFF};
      end
      default: ;
    endcase

    rsp_valid_nxt = (state_nxt == RESP);
    busy_nxt      = (state_nxt != IDLE);
    cmd_ready_nxt = (state_nxt == IDLE);

    tmr_clear = (state_nxt != state);
    tmr_en    = is_wb_state(state);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_p_o     <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'h0;
      wbm_adr_o   <= 32'h0;
      wbm_dat_o   <= 32'h0;
    end else begin
      state       <= state_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      cmd_ready_o <= cmd_ready_nxt;
      rsp_valid_o <= rsp_valid_nxt;
      rsp_p_o     <= rsp_p_nxt;
      rsp_err_o   <= rsp_err_nxt;
      busy_o      <= busy_nxt;
      wbm_cyc_o   <= cyc_nxt;
      wbm_stb_o   <= stb_nxt;
      wbm_we_o    <= we_nxt;
      wbm_sel_o   <= sel_nxt;
      wbm_adr_o   <= adr_nxt;
      wbm_dat_o   <= dat_nxt;
    end
  end

endmodule

// File: tb/tb_mult_wb_initiator.sv
// Bench for mult_wb_initiator. Two instances: dut0 with the default
// TIMEOUT and dut1 with TIMEOUT=8, each with its own multiplier slave model
// whose per-register ack latency is configurable (cfg = number of cycles
// stb is held before ack, 0 = never ack).
module tb_mult_wb_initiator;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [15:0] cmd_a, cmd_b;
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_p     [2];
  logic        rsp_err   [2];
  logic        cyc [2], stb [2], we [2];
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        busy [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_wb_initiator #(.BASE_ADDR(BASE)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_p_o(rsp_p[0]), .rsp_err_o(rsp_err[0]),
    .wbm_cyc_o(cyc[0]), .wbm_stb_o(stb[0]), .wbm_we_o(we[0]),
    .wbm_sel_o(sel[0]), .wbm_adr_o(adr[0]), .wbm_dat_o(wdat[0]),
    .wbm_ack_i(ack[0]), .wbm_dat_i(rdat[0]), .busy_o(busy[0])
  );

  mult_wb_initiator #(.BASE_ADDR(BASE), .TIMEOUT(8)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_p_o(rsp_p[1]), .rsp_err_o(rsp_err[1]),
    .wbm_cyc_o(cyc[1]), .wbm_stb_o(stb[1]), .wbm_we_o(we[1]),
    .wbm_sel_o(sel[1]), .wbm_adr_o(adr[1]), .wbm_dat_o(wdat[1]),
    .wbm_ack_i(ack[1]), .wbm_dat_i(rdat[1]), .busy_o(busy[1])
  );

  // ---------------- slave models ----------------
  int          cfg   [2][4];
  bit          stray [2];
  logic [15:0] mem   [2][2];
  int          wcnt  [2];

  // 0/1/2 = A/B/P register, 3 = not a register address
  function automatic int idx_of(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off[1:0] == 2'b00 && off < 32'd12) return int'(off[3:2]);
    return 3;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      ack[d] = stray[d];
      if (cyc[d] && stb[d] && cfg[d][idx_of(adr[d])] != 0 &&
          wcnt[d] == cfg[d][idx_of(adr[d])] - 1)
        ack[d] = 1'b1;
      rdat[d] = {16'h0, mem[d][0]} * {16'h0, mem[d][1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) wcnt[d] <= 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (cyc[d] && stb[d] && !ack[d]) wcnt[d] <= wcnt[d] + 1;
        else                             wcnt[d] <= 0;
        if (cyc[d] && stb[d] && ack[d] && we[d] && idx_of(adr[d]) < 2)
          mem[d][idx_of(adr[d])] <= wdat[d][15:0];
      end
    end
  end

  // ---------------- bus monitor ----------------
  int          stb_seen  [2][4];
  int          prot_err  [2];
  bit          prev_hold [2];
  logic [31:0] prev_adr  [2];
  logic [31:0] prev_dat  [2];
  int          mon_i;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        prev_hold[d] = 1'b0;
      end else begin
        if (cyc[d] !== stb[d]) prot_err[d]++;
        if (cyc[d]) begin
          mon_i = idx_of(adr[d]);
          stb_seen[d][mon_i]++;
          if (mon_i == 3 || sel[d] != 4'hF || we[d] != (mon_i != 2) ||
              (mon_i == 2 && wdat[d] != 32'h0))
            prot_err[d]++;
          if (prev_hold[d] && (adr[d] != prev_adr[d] || wdat[d] != prev_dat[d]))
            prot_err[d]++;
          prev_hold[d] = !ack[d];
          prev_adr[d]  = adr[d];
          prev_dat[d]  = wdat[d];
        end else begin
          if (stb[d] || we[d] || sel[d] != 4'h0 || adr[d] != 32'h0 || wdat[d] != 32'h0)
            prot_err[d]++;
          prev_hold[d] = 1'b0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer a command; accepted at the next rising edge.
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b);
    int k;
    k = 0;
    while (!cmd_ready[d] && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready before issue", 32'(cmd_ready[d]), 32'd1);
    cmd_a = a;
    cmd_b = b;
    cmd_valid[d] = 1'b1;
  endtask

  // Counts cycles after the accept cycle until rsp_valid (0 = never seen).
  task automatic wait_rsp(input int d, output int lat, output int rdy_seen);
    int n;
    n = 0;
    lat = 0;
    rdy_seen = 0;
    while (lat == 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) cmd_valid[d] = 1'b0;
      if (rsp_valid[d]) lat = n;
      else if (cmd_ready[d]) rdy_seen++;
    end
  endtask

  task automatic handshake(input int d);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("rsp_valid after handshake", 32'(rsp_valid[d]), 32'd0);
    chk("cmd_ready after handshake", 32'(cmd_ready[d]), 32'd1);
    chk("busy after handshake", 32'(busy[d]), 32'd0);
  endtask

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [15:0] b;
    int          ca, cb, cp;
    logic [31:0] exp_p;
    logic        exp_err;
    int          exp_lat;
    int          exp_nb;
    int          exp_np;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input vec_t v);
    int lat, rdy, nb0, np0, pe0;
    cfg[v.d][0] = v.ca;
    cfg[v.d][1] = v.cb;
    cfg[v.d][2] = v.cp;
    cfg[v.d][3] = 0;
    nb0 = stb_seen[v.d][1];
    np0 = stb_seen[v.d][2];
    pe0 = prot_err[v.d];
    issue(v.d, v.a, v.b);
    wait_rsp(v.d, lat, rdy);
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("rsp_p", rsp_p[v.d], v.exp_p);
    chk("rsp_err", 32'(rsp_err[v.d]), 32'(v.exp_err));
    chk("busy in RESP", 32'(busy[v.d]), 32'd1);
    chk("stb cycles on B", 32'(stb_seen[v.d][1] - nb0), 32'(v.exp_nb));
    chk("stb cycles on P", 32'(stb_seen[v.d][2] - np0), 32'(v.exp_np));
    chk("bus protocol errors", 32'(prot_err[v.d] - pe0), 32'd0);
    chk("cmd_ready while busy", 32'(rdy), 32'd0);
    chk("slave reg A", 32'(mem[v.d][0]), 32'(v.a));
    if (v.cb != 0) chk("slave reg B", 32'(mem[v.d][1]), 32'(v.b));
    handshake(v.d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat, rdy, n, cnt;
    bit found;

    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0;
      rsp_ready[d] = 1'b0;
      stray[d]     = 1'b0;
      for (int r = 0; r < 4; r++) cfg[d][r] = 1;
    end
    cmd_a = 16'h0;
    cmd_b = 16'h0;

    //           d  a         b         ca cb cp  exp_p          err  lat nb np
    vecs[0] = '{0, 16'h0003, 16'h0005, 1, 1, 1,  32'h0000_000F, 1'b0, 4,  1, 1};
    vecs[1] = '{0, 16'hFFFF, 16'hFFFF, 1, 1, 10, 32'hFFFE_0001, 1'b0, 13, 1, 10};
    vecs[2] = '{0, 16'h1234, 16'h5678, 1, 1, 1,  32'h0626_0060, 1'b0, 4,  1, 1};
    vecs[3] = '{0, 16'h0000, 16'hBEEF, 1, 1, 1,  32'h0000_0000, 1'b0, 4,  1, 1};
    vecs[4] = '{0, 16'h8000, 16'h0002, 3, 2, 1,  32'h0001_0000, 1'b0, 7,  2, 1};
    vecs[5] = '{1, 16'h0003, 16'h0005, 1, 0, 1,  32'h0000_0000, 1'b1, 10, 8, 0};
    vecs[6] = '{1, 16'h00FF, 16'h0101, 1, 1, 8,  32'h0000_FFFF, 1'b0, 11, 1, 8};
    vecs[7] = '{1, 16'h0002, 16'h0003, 1, 1, 0,  32'h0000_0000, 1'b1, 11, 1, 8};
    vecs[8] = '{1, 16'h0004, 16'h0004, 1, 1, 1,  32'h0000_0010, 1'b0, 4,  1, 1};

    // reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset cmd_ready", 32'(cmd_ready[d]), 32'd0);
      chk("reset cyc", 32'(cyc[d]), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset busy", 32'(busy[d]), 32'd0);
      chk("reset rsp_p", rsp_p[d], 32'h0);
    end
    rst = 1'b0;
    #1;
    chk("cmd_ready before first edge", 32'(cmd_ready[0]), 32'd0);
    @(negedge clk);
    chk("cmd_ready after first edge", 32'(cmd_ready[0]), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // response back-pressure; cmd_valid and a stray ack during RESP are ignored
    cfg[0][0] = 1; cfg[0][1] = 1; cfg[0][2] = 1;
    issue(0, 16'h0010, 16'h0011);
    wait_rsp(0, lat, rdy);
    chk("bp latency", 32'(lat), 32'd4);
    chk("bp rsp_p", rsp_p[0], 32'h0000_0110);
    cmd_a = 16'h0007;
    cmd_b = 16'h0009;
    cmd_valid[0] = 1'b1;
    stray[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp rsp_valid held", 32'(rsp_valid[0]), 32'd1);
      chk("bp rsp_p held", rsp_p[0], 32'h0000_0110);
      chk("bp cmd_ready low", 32'(cmd_ready[0]), 32'd0);
      chk("bp cyc low", 32'(cyc[0]), 32'd0);
    end
    stray[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    chk("bp rsp_valid dropped", 32'(rsp_valid[0]), 32'd0);
    chk("bp cmd_ready back", 32'(cmd_ready[0]), 32'd1);
    wait_rsp(0, lat, rdy);
    chk("bp second latency", 32'(lat), 32'd4);
    chk("bp second rsp_p", rsp_p[0], 32'h0000_003F);
    chk("bp second cmd_ready while busy", 32'(rdy), 32'd0);
    handshake(0);

    // reset while reading the product
    cfg[0][0] = 1; cfg[0][1] = 1; cfg[0][2] = 10;
    issue(0, 16'h0006, 16'h0007);
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      cmd_valid[0] = 1'b0;
      if (cyc[0] && adr[0] == BASE + 32'h8) found = 1'b1;
    end
    chk("reached RD_P", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset cyc", 32'(cyc[0]), 32'd0);
    chk("async reset stb", 32'(stb[0]), 32'd0);
    @(negedge clk);
    chk("mid reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid reset cmd_ready", 32'(cmd_ready[0]), 32'd0);
    chk("mid reset busy", 32'(busy[0]), 32'd0);
    chk("mid reset adr", adr[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) cnt++;
    end
    chk("no response after reset", 32'(cnt), 32'd0);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
